redirect_ctrl: RTL and testbench
================================

# redirect_ctrl

Sequences front-end redirects for the five-stage core. It collects resolved branch/jump outcomes from the execute-stage branch unit and trap/xRET/CSR redirects from commit. It then issues a single prioritised PC redirect to fetch, flushes wrong-path stages, and holds the redirect while an instruction-bus fetch is still in flight so the stale response is discarded. It sits between the execute/commit stages and the fetch PC register, and keeps branch statistics counters.

## Interface
- No parameters. Widths fixed: PC/target u64, counters u32.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_stall  in  1  EX held this cycle; ex_fire = ex_valid & ~ex_stall
- ex_branch  in  1  instruction is a branch/jump (ctl.branch)
- ex_taken  in  1  branch unit taken result
- ex_target  in  64  branch unit target
- cm_redirect_valid  in  1  commit-stage redirect (trap, xRET, CSR serialise)
- cm_redirect_pc  in  64  commit redirect target
- ibus_busy  in  1  fetch has an outstanding ibus request
- ibus_data_ok  in  1  outstanding request completes this cycle
- redirect_valid  out  1  load redirect_pc into fetch PC at next edge
- redirect_pc  out  64  redirect target
- flush_front  out  1  kill IF/ID contents and ID→EX transfer at next edge
- flush_ex  out  1  kill EX→MEM transfer at next edge (commit redirect only)
- fetch_hold  out  1  fetch must not issue a new ibus request
- drop_resp  out  1  discard the ibus response returned this cycle
- misalign_valid  out  1  taken target not 4-byte aligned (pulse)
- misalign_addr  out  64  offending target
- branch_cnt  out  32  retired-in-EX branch/jump count
- taken_cnt  out  32  taken count

## Operation
- States: IDLE, PEND.
- Event selection each cycle. Priority: cm_redirect_valid > (ex_fire & ex_branch & ex_taken & ex_target[1:0]==0) in IDLE. In PEND, only cm_redirect_valid counts; EX events are wrong-path and ignored.
- IDLE, commit event: flush_front=1, flush_ex=1. Any simultaneous EX event is dropped and not counted.
- IDLE, accepted EX event: flush_front=1, flush_ex=0.
- Dispatch from IDLE:
  - If ibus_busy & ~ibus_data_ok: latch target into pend_pc, go to PEND, fetch_hold=1, redirect_valid=0.
  - Else: redirect_valid=1, redirect_pc=target, stay IDLE. If ibus_data_ok is set that cycle, also drop_resp=1.
- PEND:
  - fetch_hold=1 every cycle.
  - cm_redirect_valid overwrites pend_pc and pulses flush_front and flush_ex.
  - On ibus_data_ok: drop_resp=1, redirect_valid=1, redirect_pc = pend_pc, or cm_redirect_pc if it arrives that same cycle. Return to IDLE.
- Misalign: ex_fire & ex_branch & ex_taken & ex_target[1:0]!=0 in IDLE with no commit event.
  - misalign_valid=1, misalign_addr=ex_target.
  - No redirect, no flush; commit handles the trap.
- Counters, IDLE only, suppressed by a same-cycle commit event:
  - branch_cnt += 1 on ex_fire & ex_branch.
  - taken_cnt += 1 when that instruction is also taken, including misaligned.
  - Both wrap modulo 2^32.
- Reset (any time, including mid-PEND): state IDLE, pend_pc=0, counters 0, all outputs 0. A pending redirect is discarded.

## Timing
- redirect, flush and misalign outputs are combinational from the current inputs and state. All are single-cycle pulses except fetch_hold, which is level while in PEND.
- Redirect latency:
  - 0 cycles when fetch is idle.
  - k cycles when ibus_data_ok arrives k cycles after the event; redirect asserts in the data_ok cycle.
- State, pend_pc and counters update on posedge clk. Reset is asynchronous on the negedge of resetn.
- ex_stall=1 blocks every EX-sourced action, so an instruction held in EX is counted and redirected exactly once.

## Structure
- Add `redirect_state_t` (IDLE, PEND) to package common; reuse the existing u32/u64 typedefs.
- Put the target-selection and priority logic inline.
- One sub-module: `branch_perf_cnt`, a pair of wrapping 32-bit counters with inc_branch/inc_taken inputs.

## Test plan
- Taken BEQ, fetch idle: ex_fire, ex_taken, ex_target=0x8000_0100 → same cycle redirect_valid=1, redirect_pc=0x8000_0100, flush_front=1; branch_cnt=1, taken_cnt=1.
- Taken JAL with ibus_busy, data_ok 3 cycles later → PEND. fetch_hold=1 for 3 cycles, then redirect_valid=1 and drop_resp=1 in the data_ok cycle, then IDLE.
- Commit redirect 0x8000_0004 same cycle as taken branch to 0x8000_0200 → redirect_pc=0x8000_0004, flush_ex=1, counters unchanged.
- Commit redirect 0x8000_0040 during PEND, then data_ok → redirect_pc=0x8000_0040; EX events during PEND neither redirect nor count.
- Taken JALR target 0x8000_0102 → misalign_valid=1, misalign_addr=0x8000_0102, no redirect or flush; taken_cnt increments. Not-taken branch → only branch_cnt increments.
- resetn low mid-PEND → next cycle IDLE, no redirect on the later data_ok, counters 0. Also cover branch_cnt wrap from 0xFFFF_FFFF to 0.

Source files
------------

// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the front-end redirect sequencer.
package redirect_ctrl_pkg;

   typedef logic [31:0] u32;
   typedef logic [63:0] u64;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } redirect_state_t;

   function automatic logic is_word_aligned(input u64 addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// Signal bundle between execute/commit/fetch and the redirect sequencer.
interface redirect_ctrl_if;
   import redirect_ctrl_pkg::*;

   logic ex_valid;
   logic ex_stall;
   logic ex_branch;
   logic ex_taken;
   u64   ex_target;
   logic cm_redirect_valid;
   u64   cm_redirect_pc;
   logic ibus_busy;
   logic ibus_data_ok;
   logic redirect_valid;
   u64   redirect_pc;
   logic flush_front;
   logic flush_ex;
   logic fetch_hold;
   logic drop_resp;
   logic misalign_valid;
   u64   misalign_addr;
   u32   branch_cnt;
   u32   taken_cnt;

   modport slave (
      input  ex_valid, ex_stall, ex_branch, ex_taken, ex_target,
      input  cm_redirect_valid, cm_redirect_pc, ibus_busy, ibus_data_ok,
      output redirect_valid, redirect_pc, flush_front, flush_ex,
      output fetch_hold, drop_resp, misalign_valid, misalign_addr,
      output branch_cnt, taken_cnt
   );

   modport master (
      output ex_valid, ex_stall, ex_branch, ex_taken, ex_target,
      output cm_redirect_valid, cm_redirect_pc, ibus_busy, ibus_data_ok,
      input  redirect_valid, redirect_pc, flush_front, flush_ex,
      input  fetch_hold, drop_resp, misalign_valid, misalign_addr,
      input  branch_cnt, taken_cnt
   );

endinterface

// File: rtl/redirect_ctrl_branch_perf_cnt.sv
// Pair of free-running, wrapping 32-bit branch statistics counters.
module branch_perf_cnt
   import redirect_ctrl_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic inc_branch,
   input  logic inc_taken,
   output u32   branch_cnt,
   output u32   taken_cnt
);

   u32 branch_q;
   u32 taken_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         branch_q <= '0;
         taken_q  <= '0;
      end else begin
         if (inc_branch) branch_q <= branch_q + 32'd1;
         if (inc_taken)  taken_q  <= taken_q + 32'd1;
      end
   end

   assign branch_cnt = branch_q;
   assign taken_cnt  = taken_q;

endmodule

// File: rtl/redirect_ctrl.sv
// Prioritises commit and execute redirects into one fetch PC redirect,
// holding it while an ibus fetch is in flight so the stale response is dropped.
module redirect_ctrl
   import redirect_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   redirect_ctrl_if.slave  bus
);

   redirect_state_t state_q, state_d;
   u64              pend_pc_q, pend_pc_d;

   logic ex_br, ex_tk;
   logic evt;
   u64   evt_pc;
   logic rv, ff, fe, fh, dr, mv;
   u64   rpc, ma;
   logic inc_b, inc_t;

   // A stalled EX instruction is invisible until the cycle it actually moves on.
   assign ex_br = bus.ex_valid & ~bus.ex_stall & bus.ex_branch;
   assign ex_tk = ex_br & bus.ex_taken;

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      evt       = 1'b0;
      evt_pc    = '0;
      rv        = 1'b0;
      rpc       = '0;
      ff        = 1'b0;
      fe        = 1'b0;
      fh        = 1'b0;
      dr        = 1'b0;
      mv        = 1'b0;
      ma        = '0;
      inc_b     = 1'b0;
      inc_t     = 1'b0;
      case (state_q)
         IDLE: begin
            inc_b = ex_br & ~bus.cm_redirect_valid;
            inc_t = ex_tk & ~bus.cm_redirect_valid;
            if (bus.cm_redirect_valid) begin
               evt    = 1'b1;
               evt_pc = bus.cm_redirect_pc;
               ff     = 1'b1;
               fe     = 1'b1;
            end else if (ex_tk && is_word_aligned(bus.ex_target)) begin
               evt    = 1'b1;
               evt_pc = bus.ex_target;
               ff     = 1'b1;
            end else if (ex_tk) begin
               mv = 1'b1;
               ma = bus.ex_target;
            end
            if (evt) begin
               if (bus.ibus_busy && !bus.ibus_data_ok) begin
                  pend_pc_d = evt_pc;
                  state_d   = PEND;
                  fh        = 1'b1;
               end else begin
                  rv  = 1'b1;
                  rpc = evt_pc;
                  dr  = bus.ibus_data_ok;
               end
            end
         end
         PEND: begin
            // Everything arriving from EX here is wrong-path and is ignored.
            fh = 1'b1;
            if (bus.cm_redirect_valid) begin
               pend_pc_d = bus.cm_redirect_pc;
               ff        = 1'b1;
               fe        = 1'b1;
            end
            if (bus.ibus_data_ok) begin
               dr      = 1'b1;
               rv      = 1'b1;
               rpc     = bus.cm_redirect_valid ? bus.cm_redirect_pc : pend_pc_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   branch_perf_cnt u_perf (
      .clk        (clk),
      .resetn     (resetn),
      .inc_branch (inc_b),
      .inc_taken  (inc_t),
      .branch_cnt (bus.branch_cnt),
      .taken_cnt  (bus.taken_cnt)
   );

   // Combinational outputs are forced quiet while reset is held.
   assign bus.redirect_valid = resetn & rv;
   assign bus.redirect_pc    = resetn ? rpc : '0;
   assign bus.flush_front    = resetn & ff;
   assign bus.flush_ex       = resetn & fe;
   assign bus.fetch_hold     = resetn & fh;
   assign bus.drop_resp      = resetn & dr;
   assign bus.misalign_valid = resetn & mv;
   assign bus.misalign_addr  = resetn ? ma : '0;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed scoreboard bench for redirect_ctrl.
module tb_redirect_ctrl;
   import redirect_ctrl_pkg::*;

   typedef struct {
      string tag;
      logic  rv;
      u64    rpc;
      logic  ff;
      logic  fe;
      logic  fh;
      logic  dr;
      logic  mv;
      u64    ma;
      u32    bc;
      u32    tc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   u32   exp_bc = 0;
   u32   exp_tc = 0;
   exp_t sb[$];

   redirect_ctrl_if bus ();

   redirect_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic br, input logic tk,
                        input u64 tgt, input logic cmv, input u64 cmpc,
                        input logic busy, input logic ok);
      bus.ex_valid          = v;
      bus.ex_stall          = st;
      bus.ex_branch         = br;
      bus.ex_taken          = tk;
      bus.ex_target         = tgt;
      bus.cm_redirect_valid = cmv;
      bus.cm_redirect_pc    = cmpc;
      bus.ibus_busy         = busy;
      bus.ibus_data_ok      = ok;
   endtask

   // Queue the expected outputs, sample mid-cycle, advance one clock.
   task automatic step(input string tag, input logic rv, input u64 rpc, input logic ff,
                       input logic fe, input logic fh, input logic dr, input logic mv,
                       input u64 ma, input int inc_b, input int inc_t);
      exp_t e;
      e = '{tag, rv, rpc, ff, fe, fh, dr, mv, ma, exp_bc, exp_tc};
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      chk({e.tag, ".redirect_valid"}, {63'd0, bus.redirect_valid}, {63'd0, e.rv});
      chk({e.tag, ".redirect_pc"},    bus.redirect_pc, e.rpc);
      chk({e.tag, ".flush_front"},    {63'd0, bus.flush_front}, {63'd0, e.ff});
      chk({e.tag, ".flush_ex"},       {63'd0, bus.flush_ex}, {63'd0, e.fe});
      chk({e.tag, ".fetch_hold"},     {63'd0, bus.fetch_hold}, {63'd0, e.fh});
      chk({e.tag, ".drop_resp"},      {63'd0, bus.drop_resp}, {63'd0, e.dr});
      chk({e.tag, ".misalign_valid"}, {63'd0, bus.misalign_valid}, {63'd0, e.mv});
      chk({e.tag, ".misalign_addr"},  bus.misalign_addr, e.ma);
      chk({e.tag, ".branch_cnt"},     {32'd0, bus.branch_cnt}, {32'd0, e.bc});
      chk({e.tag, ".taken_cnt"},      {32'd0, bus.taken_cnt}, {32'd0, e.tc});
      @(posedge clk);
      exp_bc = exp_bc + u32'(inc_b);
      exp_tc = exp_tc + u32'(inc_t);
      @(negedge clk);
   endtask

   initial begin
      drive(0, 0, 0, 0, '0, 0, '0, 0, 0);
      @(negedge clk);
      step("reset", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
      resetn = 1'b1;

      // taken branch, fetch idle
      drive(1, 0, 1, 1, 64'h8000_0100, 0, '0, 0, 0);
      step("beq_idle", 1, 64'h8000_0100, 1, 0, 0, 0, 0, '0, 1, 1);
      drive(0, 0, 0, 0, '0, 0, '0, 0, 0);
      step("after_beq", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);

      // taken jump with fetch busy, data_ok three cycles later
      drive(1, 0, 1, 1, 64'h8000_0200, 0, '0, 1, 0);
      step("jal_busy", 0, '0, 1, 0, 1, 0, 0, '0, 1, 1);
      drive(0, 0, 0, 0, '0, 0, '0, 1, 0);
      step("pend1", 0, '0, 0, 0, 1, 0, 0, '0, 0, 0);
      drive(1, 0, 1, 1, 64'h8000_0300, 0, '0, 1, 0);
      step("pend_ex_ignored", 0, '0, 0, 0, 1, 0, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, '0, 1, 1);
      step("pend_data_ok", 1, 64'h8000_0200, 0, 0, 1, 1, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, '0, 0, 0);
      step("back_idle", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);

      // commit wins over a simultaneous taken branch
      drive(1, 0, 1, 1, 64'h8000_0200, 1, 64'h8000_0004, 0, 0);
      step("cm_vs_ex", 1, 64'h8000_0004, 1, 1, 0, 0, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, '0, 0, 0);
      step("cm_no_count", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);

      // commit overwrites a pending redirect
      drive(1, 0, 1, 1, 64'h8000_0400, 0, '0, 1, 0);
      step("pend_enter2", 0, '0, 1, 0, 1, 0, 0, '0, 1, 1);
      drive(0, 0, 0, 0, '0, 1, 64'h8000_0040, 1, 0);
      step("pend_cm", 0, '0, 1, 1, 1, 0, 0, '0, 0, 0);
      drive(0, 0, 0, 0, '0, 0, '0, 1, 1);
      step("pend_cm_data_ok", 1, 64'h8000_0040, 0, 0, 1, 1, 0, '0, 0, 0);

      // commit arriving in the data_ok cycle itself
      drive(1, 0, 1, 1, 64'h8000_0500, 0, '0, 1, 0);
      step("pend_enter3", 0, '0, 1, 0, 1, 0, 0, '0, 1, 1);
      drive(0, 0, 0, 0, '0, 1, 64'h8000_0080, 1, 1);
      step("pend_cm_same_ok", 1, 64'h8000_0080, 1, 1, 1, 1, 0, '0, 0, 0);

      // immediate redirect with the outstanding response landing this cycle
      drive(1, 0, 1, 1, 64'h8000_0600, 0, '0, 1, 1);
      step("idle_ok_drop", 1, 64'h8000_0600, 1, 0, 0, 1, 0, '0, 1, 1);

      // misaligned taken target, then a not-taken branch, then a stalled one
      drive(1, 0, 1, 1, 64'h8000_0102, 0, '0, 0, 0);
      step("misalign", 0, '0, 0, 0, 0, 0, 1, 64'h8000_0102, 1, 1);
      drive(1, 0, 1, 0, 64'h8000_0700, 0, '0, 0, 0);
      step("not_taken", 0, '0, 0, 0, 0, 0, 0, '0, 1, 0);
      drive(1, 1, 1, 1, 64'h8000_0800, 0, '0, 0, 0);
      step("stalled", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
      drive(1, 0, 0, 1, 64'h8000_0900, 0, '0, 0, 0);
      step("non_branch", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);

      // asynchronous reset in the middle of a pending redirect
      drive(1, 0, 1, 1, 64'h8000_0a00, 0, '0, 1, 0);
      step("pend_enter4", 0, '0, 1, 0, 1, 0, 0, '0, 1, 1);
      drive(0, 0, 0, 0, '0, 0, '0, 1, 0);
      resetn = 1'b0;
      exp_bc = 0;
      exp_tc = 0;
      step("reset_mid_pend", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
      resetn = 1'b1;
      drive(0, 0, 0, 0, '0, 0, '0, 1, 1);
      step("late_data_ok", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);

      // branch counter wrap
      drive(0, 0, 0, 0, '0, 0, '0, 0, 0);
      force dut.u_perf.branch_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_perf.branch_q;
      exp_bc = 32'hFFFF_FFFF;
      drive(1, 0, 1, 0, 64'h8000_0b00, 0, '0, 0, 0);
      step("wrap_pre", 0, '0, 0, 0, 0, 0, 0, '0, 1, 0);
      drive(0, 0, 0, 0, '0, 0, '0, 0, 0);
      step("wrap_post", 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
